// File: rtl/bsg_priority_crossbar.sv
// Priority-select crossbar: each output priority-encodes its request row to a
// one-hot select that drives an AND-OR word mux, with a 1-cycle registered copy.
module bsg_priority_crossbar #(
    parameter int i_els_p    = 4,
    parameter int o_els_p    = 1,
    parameter int width_p    = 64,
    parameter int lo_to_hi_p = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [i_els_p*width_p-1:0] data_i,
    input  logic [o_els_p*i_els_p-1:0] req_i,
    output logic [o_els_p*i_els_p-1:0] sel_one_hot_o,
    output logic [o_els_p-1:0]         v_o,
    output logic [o_els_p*width_p-1:0] data_o,
    output logic [o_els_p-1:0]         v_r_o,
    output logic [o_els_p*width_p-1:0] data_r_o
);

    if (i_els_p < 1 || o_els_p < 1 || width_p < 1) begin : g_bad_params
        $error("bsg_priority_crossbar: i_els_p, o_els_p and width_p must all be >= 1");
    end

    function automatic logic [i_els_p-1:0] reverse_bits(input logic [i_els_p-1:0] x);
        logic [i_els_p-1:0] r;
        for (int k = 0; k < i_els_p; k++) begin
            r[k] = x[i_els_p-1-k];
        end
        return r;
    endfunction

    // x & -x keeps only the lowest set bit; all-zero in gives all-zero out.
    function automatic logic [i_els_p-1:0] isolate_lowest(input logic [i_els_p-1:0] x);
        return x & (~x + i_els_p'(1));
    endfunction

    for (genvar j = 0; j < o_els_p; j++) begin : g_row
        logic [i_els_p-1:0] row_req;
        logic [i_els_p-1:0] sel_row;
        logic [width_p-1:0] row_data;

        assign row_req = req_i[j*i_els_p +: i_els_p];

        if (lo_to_hi_p != 0) begin : g_lo_first
            assign sel_row = isolate_lowest(row_req);
        end else begin : g_hi_first
            assign sel_row = reverse_bits(isolate_lowest(reverse_bits(row_req)));
        end

        // NOTE: default assignment before the loop keeps this purely combinational (no latch).
        always_comb begin
            row_data = '0;
            for (int k = 0; k < i_els_p; k++) begin
                row_data |= {width_p{sel_row[k]}} & data_i[k*width_p +: width_p];
            end
        end

        assign sel_one_hot_o[j*i_els_p +: i_els_p] = sel_row;
        assign v_o[j]                              = |row_req;
        assign data_o[j*width_p +: width_p]        = row_data;
    end

    logic [o_els_p-1:0]         v_d, v_q;
    logic [o_els_p*width_p-1:0] data_d, data_q;

    assign v_d    = v_o;
    assign data_d = data_o;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q    <= '0;
            data_q <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v_r_o    = v_q;
    assign data_r_o = data_q;

endmodule

// File: tb/tb_bsg_priority_crossbar.sv
// Self-checking bench for bsg_priority_crossbar: directed cases on several
// parameterisations plus a randomized run with a registered-output scoreboard.
module tb_bsg_priority_crossbar;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        v;
        logic [63:0] d;
    } exp_t;
    exp_t sb_q[$];

    // 4 inputs, 1 output, lowest index wins
    logic [255:0] lo_data;
    logic [3:0]   lo_req, lo_sel;
    logic         lo_v, lo_v_r;
    logic [63:0]  lo_dout, lo_dout_r;

    bsg_priority_crossbar #(.i_els_p(4), .o_els_p(1), .width_p(64), .lo_to_hi_p(1)) u_lo (
        .clk_i(clk), .reset_i(rst), .data_i(lo_data), .req_i(lo_req),
        .sel_one_hot_o(lo_sel), .v_o(lo_v), .data_o(lo_dout),
        .v_r_o(lo_v_r), .data_r_o(lo_dout_r)
    );

    // 4 inputs, 1 output, highest index wins
    logic [255:0] hi_data;
    logic [3:0]   hi_req, hi_sel;
    logic         hi_v, hi_v_r;
    logic [63:0]  hi_dout, hi_dout_r;

    bsg_priority_crossbar #(.i_els_p(4), .o_els_p(1), .width_p(64), .lo_to_hi_p(0)) u_hi (
        .clk_i(clk), .reset_i(rst), .data_i(hi_data), .req_i(hi_req),
        .sel_one_hot_o(hi_sel), .v_o(hi_v), .data_o(hi_dout),
        .v_r_o(hi_v_r), .data_r_o(hi_dout_r)
    );

    // 4 inputs, 3 independent outputs
    logic [255:0] mu_data;
    logic [11:0]  mu_req, mu_sel;
    logic [2:0]   mu_v, mu_v_r;
    logic [191:0] mu_dout, mu_dout_r;

    bsg_priority_crossbar #(.i_els_p(4), .o_els_p(3), .width_p(64), .lo_to_hi_p(1)) u_mu (
        .clk_i(clk), .reset_i(rst), .data_i(mu_data), .req_i(mu_req),
        .sel_one_hot_o(mu_sel), .v_o(mu_v), .data_o(mu_dout),
        .v_r_o(mu_v_r), .data_r_o(mu_dout_r)
    );

    // degenerate 1x1
    logic [7:0] one_data, one_dout, one_dout_r;
    logic       one_req, one_sel, one_v, one_v_r;

    bsg_priority_crossbar #(.i_els_p(1), .o_els_p(1), .width_p(8), .lo_to_hi_p(1)) u_one (
        .clk_i(clk), .reset_i(rst), .data_i(one_data), .req_i(one_req),
        .sel_one_hot_o(one_sel), .v_o(one_v), .data_o(one_dout),
        .v_r_o(one_v_r), .data_r_o(one_dout_r)
    );

    // Reference priority pick: scan in the losing direction so the winner is written last.
    function automatic logic [3:0] ref_sel(input logic [3:0] r, input bit lo_first);
        logic [3:0] s;
        s = '0;
        if (lo_first) begin
            for (int k = 3; k >= 0; k--) if (r[k]) s = 4'(1 << k);
        end else begin
            for (int k = 0; k < 4; k++) if (r[k]) s = 4'(1 << k);
        end
        return s;
    endfunction

    function automatic logic [63:0] ref_word(input logic [255:0] d, input logic [3:0] s);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) if (s[k]) w = d[k*64 +: 64];
        return w;
    endfunction

    localparam logic [255:0] BASE_DATA = {64'd40, 64'd30, 64'd20, 64'd10};

    task automatic test_reset();
        @(negedge clk);
        lo_data = BASE_DATA;
        lo_req  = 4'b1010;
        #1;
        n_checks++;
        if (lo_v_r !== 1'b0) begin n_fail++; $display("FAIL reset_v_r: got %0b expected 0", lo_v_r); end
        n_checks++;
        if (lo_dout_r !== 64'd0) begin n_fail++; $display("FAIL reset_data_r: got %0d expected 0", lo_dout_r); end
        n_checks++;
        if (lo_dout !== 64'd20) begin n_fail++; $display("FAIL reset_comb_data: got %0d expected 20", lo_dout); end
        @(posedge clk); #1;
        n_checks++;
        if (lo_dout_r !== 64'd0) begin n_fail++; $display("FAIL reset_hold_data_r: got %0d expected 0", lo_dout_r); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lo_priority();
        logic [3:0]  reqs [3] = '{4'b1010, 4'b1000, 4'b0000};
        logic [3:0]  sels [3] = '{4'b0010, 4'b1000, 4'b0000};
        logic [63:0] words[3] = '{64'd20, 64'd40, 64'd0};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            lo_data = BASE_DATA;
            lo_req  = reqs[i];
            #1;
            n_checks++;
            if (lo_sel !== sels[i]) begin n_fail++; $display("FAIL lo_sel[%0d]: got %b expected %b", i, lo_sel, sels[i]); end
            n_checks++;
            if (lo_dout !== words[i]) begin n_fail++; $display("FAIL lo_data[%0d]: got %0d expected %0d", i, lo_dout, words[i]); end
            n_checks++;
            if (lo_v !== (reqs[i] != 0)) begin n_fail++; $display("FAIL lo_v[%0d]: got %0b expected %0b", i, lo_v, reqs[i] != 0); end
            sb_q.push_back(exp_t'{v: (reqs[i] != 0), d: words[i]});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (lo_dout_r !== e.d) begin n_fail++; $display("FAIL lo_data_r[%0d]: got %0d expected %0d", i, lo_dout_r, e.d); end
            n_checks++;
            if (lo_v_r !== e.v) begin n_fail++; $display("FAIL lo_v_r[%0d]: got %0b expected %0b", i, lo_v_r, e.v); end
        end
    endtask

    task automatic test_hi_priority();
        @(negedge clk);
        hi_data = BASE_DATA;
        hi_req  = 4'b0110;
        #1;
        n_checks++;
        if (hi_sel !== 4'b0100) begin n_fail++; $display("FAIL hi_sel: got %b expected 0100", hi_sel); end
        n_checks++;
        if (hi_dout !== 64'd30) begin n_fail++; $display("FAIL hi_data: got %0d expected 30", hi_dout); end
        hi_req = 4'b0000;
        #1;
        n_checks++;
        if (hi_dout !== 64'd0 || hi_v !== 1'b0) begin
            n_fail++; $display("FAIL hi_zero: got data %0d v %0b expected 0 0", hi_dout, hi_v);
        end
    endtask

    task automatic test_multi_output();
        @(negedge clk);
        mu_data = BASE_DATA;
        mu_req  = {4'b1001, 4'b1100, 4'b1111};
        #1;
        n_checks++;
        if (mu_sel !== {4'b0001, 4'b0100, 4'b0001}) begin
            n_fail++; $display("FAIL multi_sel: got %b expected 000101000001", mu_sel);
        end
        n_checks++;
        if (mu_dout !== {64'd10, 64'd30, 64'd10}) begin
            n_fail++; $display("FAIL multi_data: got %h expected 10/30/10", mu_dout);
        end
        n_checks++;
        if (mu_v !== 3'b111) begin n_fail++; $display("FAIL multi_v: got %b expected 111", mu_v); end
        @(posedge clk); #1;
        n_checks++;
        if (mu_dout_r !== {64'd10, 64'd30, 64'd10}) begin
            n_fail++; $display("FAIL multi_data_r: got %h expected 10/30/10", mu_dout_r);
        end
    endtask

    task automatic test_degenerate();
        @(negedge clk);
        one_data = 8'hA5;
        one_req  = 1'b1;
        #1;
        n_checks++;
        if (one_sel !== 1'b1 || one_dout !== 8'hA5) begin
            n_fail++; $display("FAIL one_on: got sel %0b data %h expected 1 a5", one_sel, one_dout);
        end
        one_req = 1'b0;
        #1;
        n_checks++;
        if (one_sel !== 1'b0 || one_dout !== 8'h00 || one_v !== 1'b0) begin
            n_fail++; $display("FAIL one_off: got sel %0b data %h v %0b expected 0 00 0", one_sel, one_dout, one_v);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        lo_data = BASE_DATA;
        lo_req  = 4'b1010;
        @(posedge clk); #1;
        n_checks++;
        if (lo_dout_r !== 64'd20) begin n_fail++; $display("FAIL mid_pre: got %0d expected 20", lo_dout_r); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (lo_dout_r !== 64'd0 || lo_v_r !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got data %0d v %0b expected 0 0", lo_dout_r, lo_v_r);
        end
        n_checks++;
        if (lo_dout !== 64'd20 || lo_sel !== 4'b0010) begin
            n_fail++; $display("FAIL mid_comb: got data %0d sel %b expected 20 0010", lo_dout, lo_sel);
        end
        @(negedge clk);
        rst    = 1'b0;
        lo_req = 4'b1000;
        #1;
        n_checks++;
        if (lo_dout_r !== 64'd0) begin n_fail++; $display("FAIL mid_release_hold: got %0d expected 0", lo_dout_r); end
        @(posedge clk); #1;
        n_checks++;
        if (lo_dout_r !== 64'd40 || lo_v_r !== 1'b1) begin
            n_fail++; $display("FAIL mid_release_capture: got data %0d v %0b expected 40 1", lo_dout_r, lo_v_r);
        end
    endtask

    task automatic test_random();
        logic [3:0]  s_lo, s_hi;
        logic [63:0] w_lo, w_hi;
        exp_t        e;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                lo_data[k*64 +: 64] = {$urandom, $urandom};
                hi_data[k*64 +: 64] = {$urandom, $urandom};
            end
            lo_req = 4'($urandom_range(0, 15));
            hi_req = 4'($urandom_range(0, 15));
            s_lo = ref_sel(lo_req, 1'b1);
            s_hi = ref_sel(hi_req, 1'b0);
            w_lo = ref_word(lo_data, s_lo);
            w_hi = ref_word(hi_data, s_hi);
            #1;
            n_checks++;
            if (!$onehot0(lo_sel) || lo_sel !== s_lo) begin
                n_fail++; $display("FAIL rnd_lo_sel[%0d]: got %b expected %b", i, lo_sel, s_lo);
            end
            n_checks++;
            if (lo_dout !== w_lo) begin n_fail++; $display("FAIL rnd_lo_data[%0d]: got %h expected %h", i, lo_dout, w_lo); end
            n_checks++;
            if (!$onehot0(hi_sel) || hi_sel !== s_hi) begin
                n_fail++; $display("FAIL rnd_hi_sel[%0d]: got %b expected %b", i, hi_sel, s_hi);
            end
            n_checks++;
            if (hi_dout !== w_hi) begin n_fail++; $display("FAIL rnd_hi_data[%0d]: got %h expected %h", i, hi_dout, w_hi); end
            sb_q.push_back(exp_t'{v: (lo_req != 0), d: w_lo});
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_checks++;
            if (lo_dout_r !== e.d || lo_v_r !== e.v) begin
                n_fail++; $display("FAIL rnd_lo_reg[%0d]: got %h/%0b expected %h/%0b", i, lo_dout_r, lo_v_r, e.d, e.v);
            end
        end
    endtask

    initial begin
        lo_data = '0; lo_req = '0;
        hi_data = '0; hi_req = '0;
        mu_data = '0; mu_req = '0;
        one_data = '0; one_req = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_lo_priority();
        test_hi_priority();
        test_multi_output();
        test_degenerate();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
